// File: rtl/alu_addsub_sequencer.sv
// Multi-nibble add/subtract sequencer driving an external 4-bit ripple adder, one nibble per cycle.
// Optional build macro ALU_SAT_EN: saturate the result on signed overflow instead of wrapping.
module alu_addsub_sequencer #(
  parameter int NUM_NIBBLES = 2,
  localparam int W = 4 * NUM_NIBBLES,
  localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_s,
  input  logic         add_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               c_q, c_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       result_q, result_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
  logic               negative_q, negative_d;

  logic [3:0]         nib_a, nib_b;
  logic [W-1:0]       acc_next, final_res;
  logic               last_nib, ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  // Partial sums collect in acc; the visible result only changes on the final nibble.
  always_comb begin
    nib_a    = 4'h0;
    nib_b    = 4'h0;
    acc_next = acc_q;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a             = a_q[4*i +: 4];
        nib_b             = b_q[4*i +: 4];
        acc_next[4*i +: 4] = add_s;
      end
    end
    last_nib  = (idx_q == IDX_W'(NUM_NIBBLES - 1));
    ovf       = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
    final_res = acc_next;
`ifdef ALU_SAT_EN
    if (ovf) begin
      final_res = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    acc_d      = acc_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    add_a      = 4'h0;
    add_b      = 4'h0;
    add_cin    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          c_d     = op_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = nib_a;
        add_b   = nib_b;
        add_cin = c_q;
        c_d     = add_cout;
        acc_d   = acc_next;
        if (last_nib) begin
          result_d   = final_res;
          carry_d    = add_cout;
          overflow_d = ovf;
          zero_d     = (final_res == '0);
          negative_d = final_res[W-1];
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule

// File: tb/tb_alu_addsub_sequencer.sv
// Directed testbench for alu_addsub_sequencer (NUM_NIBBLES=2) with a behavioural 4-bit adder.
module tb_alu_addsub_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_sub;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;

  int n_cmp;
  int n_fail;

  alu_addsub_sequencer #(.NUM_NIBBLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  // Behavioural model of the team's 4-bit ripple adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request; returns edges from accept edge (counted as 1) to res_valid, and carry-ins seen in RUN
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        output int lat, output logic [1:0] cins);
    int guard;
    guard = 0;
    cins  = 2'b00;
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 8'h00; op_b = 8'h00; op_sub = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin
      if (lat <= 2) cins[lat-1] = add_cin;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0; op_a = 8'h00; op_b = 8'h00; op_sub = 1'b0;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
    n_cmp++; if (result !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 00", result); end
    n_cmp++; if ({carry, overflow, zero, negative} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", {carry, overflow, zero, negative}); end
    n_cmp++; if ({add_a, add_b, add_cin} !== 9'h000) begin n_fail++; $display("[TB] FAIL reset_adder: got %h expected 000", {add_a, add_b, add_cin}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    int lat; logic [1:0] cins;
    run_op(8'h3C, 8'h05, 1'b0, lat, cins);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL add_latency: got %0d expected 3", lat); end
    n_cmp++; if (result !== 8'h41) begin n_fail++; $display("[TB] FAIL add_result: got %h expected 41", result); end
    n_cmp++; if ({carry, overflow, zero, negative} !== 4'b0000) begin n_fail++; $display("[TB] FAIL add_flags: got %b expected 0000", {carry, overflow, zero, negative}); end
    // 0xC + 0x5 carries out of the low nibble, so nibble 1 sees carry-in 1
    n_cmp++; if (cins !== 2'b10) begin n_fail++; $display("[TB] FAIL add_cin_seq: got %b expected 10", cins); end
    n_cmp++; if ({add_a, add_b, add_cin} !== 9'h000) begin n_fail++; $display("[TB] FAIL add_adder_idle: got %h expected 000", {add_a, add_b, add_cin}); end
    release_result();
  endtask

  task automatic test_add_wrap();
    int lat; logic [1:0] cins;
    run_op(8'hFF, 8'h01, 1'b0, lat, cins);
    n_cmp++; if (result !== 8'h00) begin n_fail++; $display("[TB] FAIL wrap_result: got %h expected 00", result); end
    n_cmp++; if ({carry, overflow, zero, negative} !== 4'b1010) begin n_fail++; $display("[TB] FAIL wrap_flags: got %b expected 1010", {carry, overflow, zero, negative}); end
    n_cmp++; if (cins !== 2'b10) begin n_fail++; $display("[TB] FAIL wrap_cin_seq: got %b expected 10", cins); end
    release_result();
  endtask

  task automatic test_sub();
    int lat; logic [1:0] cins;
    run_op(8'h10, 8'h01, 1'b1, lat, cins);
    n_cmp++; if (result !== 8'h0F) begin n_fail++; $display("[TB] FAIL sub1_result: got %h expected 0F", result); end
    n_cmp++; if ({carry, overflow, zero, negative} !== 4'b1000) begin n_fail++; $display("[TB] FAIL sub1_flags: got %b expected 1000", {carry, overflow, zero, negative}); end
    n_cmp++; if (cins !== 2'b01) begin n_fail++; $display("[TB] FAIL sub1_cin_seq: got %b expected 01", cins); end
    release_result();
    run_op(8'h01, 8'h02, 1'b1, lat, cins);
    n_cmp++; if (result !== 8'hFF) begin n_fail++; $display("[TB] FAIL sub2_result: got %h expected FF", result); end
    n_cmp++; if ({carry, overflow, zero, negative} !== 4'b0001) begin n_fail++; $display("[TB] FAIL sub2_flags: got %b expected 0001", {carry, overflow, zero, negative}); end
    release_result();
  endtask

  task automatic test_overflow();
    int lat; logic [1:0] cins;
    logic [7:0] exp_res; logic exp_neg;
`ifdef ALU_SAT_EN
    exp_res = 8'h7F; exp_neg = 1'b0;
`else
    exp_res = 8'h80; exp_neg = 1'b1;
`endif
    run_op(8'h7F, 8'h01, 1'b0, lat, cins);
    n_cmp++; if (result !== exp_res) begin n_fail++; $display("[TB] FAIL ovf_result: got %h expected %h", result, exp_res); end
    n_cmp++; if ({carry, overflow, zero, negative} !== {3'b010, exp_neg}) begin n_fail++; $display("[TB] FAIL ovf_flags: got %b expected %b", {carry, overflow, zero, negative}, {3'b010, exp_neg}); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat; logic [1:0] cins;
    run_op(8'h12, 8'h34, 1'b0, lat, cins);
    op_a = 8'hAA; op_b = 8'h55; op_sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (result !== 8'h46) begin n_fail++; $display("[TB] FAIL bp_result[%0d]: got %h expected 46", i, result); end
      n_cmp++; if ({res_valid, in_ready, carry, overflow, zero, negative} !== 6'b100000) begin n_fail++; $display("[TB] FAIL bp_ctrl[%0d]: got %b expected 100000", i, {res_valid, in_ready, carry, overflow, zero, negative}); end
    end
    in_valid = 1'b0;
    release_result();
    n_cmp++; if ({in_ready, res_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL bp_release: got %b expected 10", {in_ready, res_valid}); end
    // res_ready outside DONE must not disturb IDLE
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_cmp++; if ({in_ready, res_valid, result} !== {2'b10, 8'h46}) begin n_fail++; $display("[TB] FAIL idle_res_ready: got %h expected 246", {in_ready, res_valid, result}); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [1:0] cins;
    op_a = 8'hFF; op_b = 8'hFF; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (add_a !== 4'hF) begin n_fail++; $display("[TB] FAIL mid_run_add_a: got %h expected F", add_a); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({add_a, add_b, add_cin} !== 9'h000) begin n_fail++; $display("[TB] FAIL mid_rst_adder: got %h expected 000", {add_a, add_b, add_cin}); end
    n_cmp++; if ({res_valid, result, carry, overflow, zero, negative} !== 13'h0000) begin n_fail++; $display("[TB] FAIL mid_rst_outputs: got %h expected 0000", {res_valid, result, carry, overflow, zero, negative}); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
    run_op(8'h22, 8'h11, 1'b0, lat, cins);
    n_cmp++; if (result !== 8'h33) begin n_fail++; $display("[TB] FAIL post_rst_result: got %h expected 33", result); end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL post_rst_latency: got %0d expected 3", lat); end
    release_result();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_add_basic();
    test_add_wrap();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
